// File: rtl/j17_pkg.sv
// Shared encodings for the j17 control unit: opcode bases, control-field
// codes and the sequencing FSM states.
package j17_pkg;

    // Base operation held in instruction bits [4:0] of the opcode field
    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_MOV  = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_MUL  = 5'd4,
        OP_DIV  = 5'd5,
        OP_MOD  = 5'd6,
        OP_OR   = 5'd7,
        OP_AND  = 5'd8,
        OP_XOR  = 5'd9,
        OP_NOT  = 5'd10,
        OP_SHR  = 5'd11,
        OP_SHL  = 5'd12,
        OP_LD   = 5'd13,
        OP_ST   = 5'd14,
        OP_BEQ  = 5'd15,
        OP_BLT  = 5'd16,
        OP_BGT  = 5'd17,
        OP_BNE  = 5'd18,
        OP_BLE  = 5'd19,
        OP_BGE  = 5'd20,
        OP_JMP  = 5'd21,
        OP_HALT = 5'd31
    } opBase_e;

    // Data-RAM access codes
    localparam logic [1:0] RAM_NONE  = 2'd0;
    localparam logic [1:0] RAM_READ  = 2'd1;
    localparam logic [1:0] RAM_WRITE = 2'd2;

    // Writeback source codes
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_RAM = 2'd2;

    // PC update modes; 1..6 are the conditional branches in opcode order
    localparam logic [2:0] PC_INC = 3'd0;
    localparam logic [2:0] PC_JMP = 3'd7;

    // Instruction sequencing states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

endpackage

// File: rtl/j17_control_unit_if.sv
// Fetch bus plus datapath control bundle between the control unit (master)
// and the instruction memory / datapath side (slave).
interface j17_control_unit_if #(
    parameter int IADDR_W = 10
);
    logic [31:0]        pc;
    logic [IADDR_W-1:0] imem_addr;
    logic               imem_req;
    logic               imem_valid;
    logic [31:0]        imem_data;
    logic [5:0]         opcode;
    logic [4:0]         op1;
    logic [20:0]        op2;
    logic [4:0]         alucode;
    logic               imControl;
    logic               regenable;
    logic [1:0]         ramenable;
    logic [2:0]         pcControl;
    logic [1:0]         writecode;
    logic               pc_en;
    logic               halted;
    logic               illegal;

    modport master (
        input  pc, imem_valid, imem_data,
        output imem_addr, imem_req, opcode, op1, op2, alucode, imControl,
               regenable, ramenable, pcControl, writecode, pc_en, halted, illegal
    );

    modport slave (
        output pc, imem_valid, imem_data,
        input  imem_addr, imem_req, opcode, op1, op2, alucode, imControl,
               regenable, ramenable, pcControl, writecode, pc_en, halted, illegal
    );
endinterface

// File: rtl/j17_decode.sv
// Combinational opcode -> control-field table for the j17 control unit.
module j17_decode
    import j17_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [4:0] alucode_o,
    output logic       imControl_o,
    output logic [2:0] pcControl_o,
    output logic [1:0] writecode_o,
    output logic [1:0] ramCode_o,
    output logic       writesReg_o,
    output logic       isMem_o,
    output logic       isHalt_o,
    output logic       isIllegal_o
);
    logic [4:0] base;

    assign base = opcode_i[4:0];

    // Map the base operation onto datapath control fields; undefined bases flag illegal
    always_comb begin
        alucode_o   = 5'd0;
        imControl_o = opcode_i[5];
        pcControl_o = PC_INC;
        writecode_o = WB_ALU;
        ramCode_o   = RAM_NONE;
        writesReg_o = 1'b0;
        isMem_o     = 1'b0;
        isHalt_o    = 1'b0;
        isIllegal_o = 1'b0;
        case (base)
            OP_NOP: ;
            OP_MOV: begin
                writesReg_o = 1'b1;
                writecode_o = opcode_i[5] ? WB_IMM : WB_ALU;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_OR, OP_AND,
            OP_XOR, OP_NOT, OP_SHR, OP_SHL: begin
                alucode_o   = base - 5'd1;
                writesReg_o = 1'b1;
            end
            OP_LD: begin
                ramCode_o   = RAM_READ;
                isMem_o     = 1'b1;
                writesReg_o = 1'b1;
                writecode_o = WB_RAM;
            end
            OP_ST: begin
                ramCode_o = RAM_WRITE;
                isMem_o   = 1'b1;
            end
            OP_BEQ, OP_BLT, OP_BGT, OP_BNE, OP_BLE, OP_BGE: begin
                pcControl_o = 3'(base - 5'd14);
            end
            OP_JMP:  pcControl_o = PC_JMP;
            OP_HALT: isHalt_o = 1'b1;
            default: isIllegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/j17_control_unit.sv
// Multi-cycle fetch/decode/sequence controller for the j17 datapath.
// One instruction at a time: FETCH, WAIT, DECODE, EXEC, optional MEM, WB.
module j17_control_unit
    import j17_pkg::*;
#(
    parameter int IADDR_W  = 10,
    parameter int IMEM_TMO = 15
) (
    input logic                clock,
    input logic                reset,
    j17_control_unit_if.master bus
);
    localparam int TMO_W = $clog2(IMEM_TMO + 1);

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [TMO_W-1:0]   tmoCnt_q, tmoCnt_d;
    logic               halted_q, halted_d;
    logic               illegal_q, illegal_d;

    logic [4:0] decAlucode;
    logic       decImControl;
    logic [2:0] decPcControl;
    logic [1:0] decWritecode;
    logic [1:0] decRamCode;
    logic       decWritesReg;
    logic       decIsMem;
    logic       decIsHalt;
    logic       decIsIllegal;
    logic       unusedPcHigh;

    j17_decode u_decode (
        .opcode_i    (ir_q[31:26]),
        .alucode_o   (decAlucode),
        .imControl_o (decImControl),
        .pcControl_o (decPcControl),
        .writecode_o (decWritecode),
        .ramCode_o   (decRamCode),
        .writesReg_o (decWritesReg),
        .isMem_o     (decIsMem),
        .isHalt_o    (decIsHalt),
        .isIllegal_o (decIsIllegal)
    );

    // PC bits above the instruction-memory window do not take part in fetch
    assign unusedPcHigh = ^bus.pc[31:IADDR_W];

    // Field outputs track the instruction register, so they hold from DECODE through WB
    assign bus.opcode    = ir_q[31:26];
    assign bus.op1       = ir_q[25:21];
    assign bus.op2       = ir_q[20:0];
    assign bus.alucode   = decAlucode;
    assign bus.imControl = decImControl;
    assign bus.pcControl = decPcControl;
    assign bus.writecode = decWritecode;
    assign bus.halted    = halted_q;
    assign bus.illegal   = illegal_q;

    // State register; reset returns to FETCH with a NOP loaded and flags cleared
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            tmoCnt_q  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            tmoCnt_q  <= tmoCnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Sequencing: next state, fetch timeout, sticky flags and strobes; strobes are held low during reset
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        tmoCnt_d      = tmoCnt_q;
        halted_d      = halted_q;
        illegal_d     = illegal_q;
        bus.imem_req  = 1'b0;
        bus.imem_addr = '0;
        bus.pc_en     = 1'b0;
        bus.regenable = 1'b0;
        bus.ramenable = RAM_NONE;
        case (state_q)
            S_FETCH: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = bus.pc[IADDR_W-1:0];
                tmoCnt_d      = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = bus.pc[IADDR_W-1:0];
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = S_DECODE;
                end else if (tmoCnt_q == TMO_W'(IMEM_TMO - 1)) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (decIsHalt) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    if (decIsIllegal) begin
                        illegal_d = 1'b1;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = decIsMem ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.ramenable = decRamCode;
                state_d       = S_WB;
            end
            S_WB: begin
                bus.ramenable = decRamCode;
                bus.pc_en     = 1'b1;
                bus.regenable = decWritesReg;
                state_d       = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            bus.imem_req  = 1'b0;
            bus.imem_addr = '0;
            bus.pc_en     = 1'b0;
            bus.regenable = 1'b0;
            bus.ramenable = RAM_NONE;
        end
    end
endmodule

// File: tb/tb_j17_control_unit.sv
// Directed bench for the j17 control unit: drives the fetch bus from tasks
// and checks strobes and fields cycle by cycle against hand-computed values.
module tb_j17_control_unit;
    import j17_pkg::*;

    // opcode in [31:26], op1 in [25:21], op2 in [20:0]
    localparam logic [31:0] INSTR_ADD  = 32'h0862_0000; // ADD r3, r3, r2 (opcode 2)
    localparam logic [31:0] INSTR_LD   = 32'h3480_0010; // LD  r4, [0x10]   (opcode 13)
    localparam logic [31:0] INSTR_ST   = 32'h38A0_0020; // ST  r5, [0x20]   (opcode 14)
    localparam logic [31:0] INSTR_BNE  = 32'h4822_0008; // BNE r1, r2, +8   (opcode 18)
    localparam logic [31:0] INSTR_ILL  = 32'h7800_0000; // undefined opcode 0x1E
    localparam logic [31:0] INSTR_HALT = 32'h7C00_0000; // HALT opcode 0x1F

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    j17_control_unit_if #(.IADDR_W(10)) bus();

    j17_control_unit #(.IADDR_W(10), .IMEM_TMO(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Hold reset across two edges and release it at a falling edge, leaving the DUT in FETCH
    task automatic doReset();
        reset = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_data = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Wait (bounded) for a fetch request, answer it after 'lag' WAIT cycles, return in DECODE
    task automatic applyStimulus(input logic [31:0] instr, input int lag, output bit seen);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        seen = (bus.imem_req === 1'b1);
        @(negedge clock);
        repeat (lag) @(negedge clock);
        bus.imem_valid = 1'b1;
        bus.imem_data = instr;
        @(negedge clock);
        bus.imem_valid = 1'b0;
        bus.imem_data = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        bus.pc = 32'h0000_0123;
        doReset();
        reset = 1'b1;
        #1;
        vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req got=%0h want=0", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL rst_addr got=%0h want=0", bus.imem_addr); end
        vectors++; if ({bus.pc_en, bus.regenable, bus.ramenable} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_strobes got=%0h want=0", {bus.pc_en, bus.regenable, bus.ramenable}); end
        vectors++; if ({bus.halted, bus.illegal} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_flags got=%0h want=0", {bus.halted, bus.illegal}); end
        vectors++; if ({bus.opcode, bus.op1, bus.op2, bus.alucode, bus.pcControl, bus.writecode, bus.imControl} !== 43'd0) begin miscompares++; $display("[TB] FAIL rst_fields got=%0h want=0", {bus.opcode, bus.op1, bus.op2}); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_req got=%0h want=1", bus.imem_req); end
        vectors++; if (bus.imem_addr !== 10'h123) begin miscompares++; $display("[TB] FAIL rst_release_addr got=%0h want=123", bus.imem_addr); end
        @(negedge clock);
    endtask

    task automatic test_add();
        bit seen;
        bit [3:0] expPcEn = 4'b0100; // index: 0 DECODE, 1 EXEC, 2 WB, 3 next FETCH
        bit [3:0] expReg  = 4'b0100;
        bit [3:0] expReq  = 4'b1000;
        doReset();
        bus.pc = 32'h0000_0405;
        #1;
        vectors++; if (bus.imem_addr !== 10'h005) begin miscompares++; $display("[TB] FAIL add_addr got=%0h want=005", bus.imem_addr); end
        applyStimulus(INSTR_ADD, 0, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL add_req_seen got=%0b want=1", seen); end
        for (int c = 0; c < 4; c++) begin
            vectors++; if (bus.pc_en !== expPcEn[c]) begin miscompares++; $display("[TB] FAIL add_pc_en c=%0d got=%0b want=%0b", c, bus.pc_en, expPcEn[c]); end
            vectors++; if (bus.regenable !== expReg[c]) begin miscompares++; $display("[TB] FAIL add_regen c=%0d got=%0b want=%0b", c, bus.regenable, expReg[c]); end
            vectors++; if (bus.imem_req !== expReq[c]) begin miscompares++; $display("[TB] FAIL add_req c=%0d got=%0b want=%0b", c, bus.imem_req, expReq[c]); end
            if (c < 3) begin
                vectors++; if ({bus.opcode, bus.op1, bus.alucode, bus.writecode, bus.imControl} !== {6'd2, 5'd3, 5'd1, 2'd0, 1'b0}) begin miscompares++; $display("[TB] FAIL add_fields c=%0d got=%0h want=%0h", c, {bus.opcode, bus.op1, bus.alucode, bus.writecode, bus.imControl}, {6'd2, 5'd3, 5'd1, 2'd0, 1'b0}); end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_ld_st();
        bit seen;
        logic [31:0] instrs [2] = '{INSTR_LD, INSTR_ST};
        logic [1:0]  ramCode [2] = '{2'd1, 2'd2};
        bit          isLoad [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            applyStimulus(instrs[k], 1, seen);
            vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL ldst_req_seen k=%0d got=%0b want=1", k, seen); end
            // index: 0 DECODE, 1 EXEC, 2 MEM, 3 WB, 4 next FETCH
            for (int c = 0; c < 5; c++) begin
                logic [1:0] expRam;
                expRam = (c == 2 || c == 3) ? ramCode[k] : 2'd0;
                vectors++; if (bus.ramenable !== expRam) begin miscompares++; $display("[TB] FAIL ldst_ram k=%0d c=%0d got=%0d want=%0d", k, c, bus.ramenable, expRam); end
                vectors++; if (bus.regenable !== (c == 3 && isLoad[k])) begin miscompares++; $display("[TB] FAIL ldst_regen k=%0d c=%0d got=%0b want=%0b", k, c, bus.regenable, (c == 3 && isLoad[k])); end
                vectors++; if (bus.pc_en !== (c == 3)) begin miscompares++; $display("[TB] FAIL ldst_pc_en k=%0d c=%0d got=%0b want=%0b", k, c, bus.pc_en, (c == 3)); end
                vectors++; if (bus.imem_req !== (c == 4)) begin miscompares++; $display("[TB] FAIL ldst_req k=%0d c=%0d got=%0b want=%0b", k, c, bus.imem_req, (c == 4)); end
                if (c == 3) begin
                    vectors++; if (bus.writecode !== (isLoad[k] ? 2'd2 : 2'd0)) begin miscompares++; $display("[TB] FAIL ldst_writecode k=%0d got=%0d want=%0d", k, bus.writecode, (isLoad[k] ? 2'd2 : 2'd0)); end
                end
                if (c < 4) @(negedge clock);
            end
        end
    endtask

    task automatic test_bne();
        bit seen;
        applyStimulus(INSTR_BNE, 2, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL bne_req_seen got=%0b want=1", seen); end
        // index: 0 DECODE, 1 EXEC, 2 WB, 3 next FETCH
        for (int c = 0; c < 4; c++) begin
            if (c == 1 || c == 2) begin
                vectors++; if (bus.pcControl !== 3'd4) begin miscompares++; $display("[TB] FAIL bne_pcctl c=%0d got=%0d want=4", c, bus.pcControl); end
            end
            if (c == 2) begin
                vectors++; if (bus.opcode !== 6'd18) begin miscompares++; $display("[TB] FAIL bne_stray_valid got=%0h want=12", bus.opcode); end
            end
            vectors++; if (bus.pc_en !== (c == 2)) begin miscompares++; $display("[TB] FAIL bne_pc_en c=%0d got=%0b want=%0b", c, bus.pc_en, (c == 2)); end
            vectors++; if (bus.regenable !== 1'b0) begin miscompares++; $display("[TB] FAIL bne_regen c=%0d got=%0b want=0", c, bus.regenable); end
            // a stray valid word during EXEC must not reach the instruction register
            bus.imem_valid = (c == 1);
            bus.imem_data = 32'hFFFF_FFFF;
            if (c < 3) @(negedge clock);
        end
        bus.imem_valid = 1'b0;
    endtask

    task automatic test_illegal_halt();
        bit seen;
        int reqCount = 0;
        applyStimulus(INSTR_ILL, 0, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_req_seen got=%0b want=1", seen); end
        // index: 0 DECODE, 1 EXEC, 2 WB, 3 next FETCH
        for (int c = 0; c < 4; c++) begin
            vectors++; if (bus.illegal !== (c >= 1)) begin miscompares++; $display("[TB] FAIL ill_flag c=%0d got=%0b want=%0b", c, bus.illegal, (c >= 1)); end
            vectors++; if (bus.pc_en !== (c == 2)) begin miscompares++; $display("[TB] FAIL ill_pc_en c=%0d got=%0b want=%0b", c, bus.pc_en, (c == 2)); end
            vectors++; if (bus.regenable !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_regen c=%0d got=%0b want=0", c, bus.regenable); end
            if (c < 3) @(negedge clock);
        end
        applyStimulus(INSTR_HALT, 0, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_req_seen got=%0b want=1", seen); end
        vectors++; if (bus.pc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_decode_pc_en got=%0b want=0", bus.pc_en); end
        @(negedge clock);
        vectors++; if (bus.halted !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_flag got=%0b want=1", bus.halted); end
        vectors++; if (dut.state_q !== S_HALT) begin miscompares++; $display("[TB] FAIL halt_state got=%0d want=%0d", dut.state_q, S_HALT); end
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req === 1'b1 || bus.pc_en === 1'b1 || bus.regenable === 1'b1) reqCount++;
            @(negedge clock);
        end
        vectors++; if (reqCount !== 0) begin miscompares++; $display("[TB] FAIL halt_parked_activity got=%0d want=0", reqCount); end
        vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_illegal_sticky got=%0b want=1", bus.illegal); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        doReset();
        vectors++; if (bus.halted !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_halted_cleared got=%0b want=0", bus.halted); end
        applyStimulus(INSTR_LD, 0, seen);
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_req_seen got=%0b want=1", seen); end
        repeat (2) @(negedge clock);
        vectors++; if (bus.ramenable !== 2'd1) begin miscompares++; $display("[TB] FAIL rmid_in_mem got=%0d want=1", bus.ramenable); end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if ({bus.imem_req, bus.pc_en, bus.regenable, bus.ramenable} !== 5'b0) begin miscompares++; $display("[TB] FAIL rmid_strobes got=%0h want=0", {bus.imem_req, bus.pc_en, bus.regenable, bus.ramenable}); end
        vectors++; if ({bus.opcode, bus.writecode, bus.halted, bus.illegal} !== 10'b0) begin miscompares++; $display("[TB] FAIL rmid_fields got=%0h want=0", {bus.opcode, bus.writecode, bus.halted, bus.illegal}); end
        vectors++; if (dut.state_q !== S_FETCH) begin miscompares++; $display("[TB] FAIL rmid_state got=%0d want=%0d", dut.state_q, S_FETCH); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_refetch got=%0b want=1", bus.imem_req); end
    endtask

    task automatic test_timeout();
        doReset();
        // FETCH, then 15 WAIT cycles with no valid; the 16th requesting cycle never happens
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            vectors++; if ({bus.imem_req, bus.halted} !== 2'b10) begin miscompares++; $display("[TB] FAIL tmo_waiting c=%0d got=%0b want=10", c, {bus.imem_req, bus.halted}); end
        end
        @(negedge clock);
        vectors++; if ({bus.imem_req, bus.halted} !== 2'b01) begin miscompares++; $display("[TB] FAIL tmo_halted got=%0b want=01", {bus.imem_req, bus.halted}); end
        vectors++; if (dut.state_q !== S_HALT) begin miscompares++; $display("[TB] FAIL tmo_state got=%0d want=%0d", dut.state_q, S_HALT); end
        bus.imem_valid = 1'b1;
        bus.imem_data = INSTR_ADD;
        @(negedge clock);
        bus.imem_valid = 1'b0;
        @(negedge clock);
        vectors++; if (bus.opcode !== 6'd0) begin miscompares++; $display("[TB] FAIL tmo_late_valid got=%0h want=0", bus.opcode); end
        vectors++; if (dut.state_q !== S_HALT) begin miscompares++; $display("[TB] FAIL tmo_still_halt got=%0d want=%0d", dut.state_q, S_HALT); end
    endtask

    initial begin
        bus.pc = '0;
        bus.imem_valid = 1'b0;
        bus.imem_data = '0;
        test_reset();
        test_add();
        test_ld_st();
        test_bne();
        test_illegal_halt();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end
endmodule
